// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding,
// datapath phase indices and the default per-phase watchdog limit.
package frame_scheduler_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } sched_state_e;

    // Datapath phases, run in this order every frame.
    localparam int PH_ERASE   = 0;
    localparam int PH_UPDATE  = 1;
    localparam int PH_COLLIDE = 2;
    localparam int PH_DRAW    = 3;

    // Width of the watchdog counter and its default limit in clk cycles.
    localparam int          WD_W            = 24;
    localparam logic [23:0] DEFAULT_TIMEOUT = 24'd1000000;

endpackage

// File: rtl/frame_scheduler_phase_watchdog.sv
// Per-phase watchdog: counts clk cycles while a phase is outstanding and
// raises expired once TIMEOUT-1 counts have elapsed since the last clear.
// The count holds at its limit so it never wraps back below it.
module phase_watchdog
    import frame_scheduler_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [WD_W-1:0] LIMIT = TIMEOUT - 24'd1;

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    // Next count: clear has priority, otherwise count up to the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + 24'd1;
        end
    end

    // Counter register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: on each divider tick launches one game frame made of
// NUM_PHASES datapath phases run strictly in order.
//
// Handshake: start[i] is a one-cycle launch pulse for phase i, decoded only
// from registered state. The phase ends on the first done[i] pulse seen in a
// later cycle (done in the launch cycle and done bits of other phases are
// ignored) or when the watchdog expires. done wins over a same-cycle timeout.
// Ticks arriving while a frame is in progress are dropped and counted.
// reset_n is active-high despite its name.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int          NUM_PHASES = 4,
    parameter logic [23:0] TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int          OVR_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  enable,
    input  logic [NUM_PHASES-1:0] done,
    output logic [NUM_PHASES-1:0] start,
    output logic [2:0]            phase,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  overrun,
    output logic [OVR_W-1:0]      overrun_count,
    output logic                  timeout_err,
    output logic [1:0]            state_dbg
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_PHASES - 1);

    sched_state_e           state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic                   overrun_q, overrun_d;
    logic [OVR_W-1:0]       ovr_cnt_q, ovr_cnt_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [NUM_PHASES-1:0]  idx_sel;
    logic                   phase_done;
    logic                   wd_clear;
    logic                   wd_en;
    logic                   wd_expired;

    // One-hot decode of the current phase index.
    always_comb begin
        idx_sel = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            idx_sel[i] = (idx_q == 3'(i));
        end
    end

    // Only the done bit belonging to the current phase matters.
    assign phase_done = |(done & idx_sel);

    phase_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset_i   (reset_n),
        .clear_i   (wd_clear),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // Next-state logic: phase sequencing, frame counting, overrun tracking.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_count_d = frame_count_q;
        overrun_d     = 1'b0;
        ovr_cnt_d     = ovr_cnt_q;
        timeout_err_d = timeout_err_q;
        wd_clear      = 1'b0;
        wd_en         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    idx_d   = 3'(PH_ERASE);
                    state_d = S_START;
                end
            end
            S_START: begin
                // Launch cycle: restart the watchdog, done is not looked at.
                wd_clear = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                if (phase_done || wd_expired) begin
                    if (!phase_done) begin
                        timeout_err_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d       = S_IDLE;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_START;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A tick during a frame (including its final cycle) is dropped.
        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != {OVR_W{1'b1}}) begin
                ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
            end
        end
    end

    // State and status registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            ovr_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            ovr_cnt_q     <= ovr_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign start         = (state_q == S_START) ? idx_sel : '0;
    assign phase         = idx_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_count   = frame_count_q;
    assign overrun       = overrun_q;
    assign overrun_count = ovr_cnt_q;
    assign timeout_err   = timeout_err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios plus a randomized run,
// all compared against a time-based reference model of the frame rules.
module tb_frame_scheduler;

    localparam int NP = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          tick = 1'b0;
    logic          enable = 1'b0;
    logic [NP-1:0] done = '0;
    logic [NP-1:0] start;
    logic [2:0]    phase;
    logic          busy;
    logic [15:0]   frame_count;
    logic          overrun;
    logic [7:0]    overrun_count;
    logic          timeout_err;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "global timeout");
    end

    frame_scheduler #(
        .NUM_PHASES (NP),
        .TIMEOUT    (24'(TO)),
        .OVR_W      (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .enable        (enable),
        .done          (done),
        .start         (start),
        .phase         (phase),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun       (overrun),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err),
        .state_dbg     (state_dbg)
    );

    logic [33:0] act;
    assign act = {start, phase, busy, frame_count, overrun, overrun_count, timeout_err};

    // ---------------- reference model ----------------
    // A frame is described by which phase is running and the cycle in which
    // that phase was launched; phase end is derived from elapsed time.
    int cyc = 0;
    int m_busy = 0;
    int m_phase = 0;
    int m_start_cyc = -100;
    int m_fc = 0;
    int m_ovr = 0;
    int m_ovrc = 0;
    int m_terr = 0;

    task automatic model_update(input logic t, input logic en, input logic [NP-1:0] d, input logic r);
        int waited;
        int got;
        cyc++;
        m_ovr = 0;
        if (r) begin
            m_busy = 0; m_phase = 0; m_fc = 0; m_ovrc = 0; m_terr = 0; m_start_cyc = -100;
        end else begin
            if (t && m_busy != 0) begin
                m_ovr = 1;
                if (m_ovrc < 255) m_ovrc++;
            end
            if (m_busy == 0) begin
                if (t && en) begin
                    m_busy = 1; m_phase = 0; m_start_cyc = cyc;
                end
            end else begin
                waited = (cyc - 1) - m_start_cyc;
                if (waited >= 1) begin
                    got = d[m_phase] ? 1 : 0;
                    if (got != 0 || waited == TO) begin
                        if (got == 0) m_terr = 1;
                        if (m_phase == NP - 1) begin
                            m_busy = 0;
                            m_fc = (m_fc + 1) % 65536;
                        end else begin
                            m_phase++;
                            m_start_cyc = cyc;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [33:0] exp_bundle();
        logic [NP-1:0] s;
        s = (m_busy != 0 && m_start_cyc == cyc) ? (4'b0001 << m_phase) : 4'b0000;
        return {s, 3'(m_phase), (m_busy != 0), 16'(m_fc), (m_ovr != 0), 8'(m_ovrc), (m_terr != 0)};
    endfunction

    // ---------------- drivers ----------------
    // Apply inputs for one cycle, advance the model, sample 1ns after the edge.
    task automatic step(input logic t, input logic en, input logic [NP-1:0] d, input logic r);
        tick = t; enable = en; done = d; reset_n = r;
        @(posedge clk);
        model_update(t, en, d, r);
        #1;
    endtask

    // Run a full frame from IDLE, returning each done dly cycles after its start.
    task automatic run_frame(input int dly);
        step(1'b1, 1'b1, '0, 1'b0);
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < dly; k++) step(1'b0, 1'b1, '0, 1'b0);
            step(1'b0, 1'b1, 4'(1 << p), 1'b0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (act !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", act, 34'd0);
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
    endtask

    task automatic test_basic_frame();
        int busy_cycles;
        int next_start;
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, '0, 1'b0);
        checks++;
        if (start !== 4'b0001) begin
            errors++;
            $display("FAIL basic_first_start: got %b expected 0001", start);
        end
        busy_cycles = busy ? 1 : 0;
        next_start = 1;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b0, 1'b1, (k == 3) ? 4'(1 << p) : 4'b0000, 1'b0);
                if (busy) busy_cycles++;
                checks++;
                if (act !== exp_bundle()) begin
                    errors++;
                    $display("FAIL basic_cycle: got %h expected %h", act, exp_bundle());
                end
                if (start != 0) begin
                    checks++;
                    if (start !== 4'(1 << next_start)) begin
                        errors++;
                        $display("FAIL basic_start_order: got %b expected %b", start, 4'(1 << next_start));
                    end
                    next_start++;
                end
            end
        end
        checks++;
        if (busy_cycles != 16) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d expected 16", busy_cycles);
        end
        checks++;
        if (frame_count !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame_end: got fc=%0d busy=%b expected fc=1 busy=0", frame_count, busy);
        end
    endtask

    task automatic test_overrun_single();
        logic t;
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, '0, 1'b0);
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 3; k++) begin
                t = (p == 2 && k == 1);
                step(t, 1'b1, '0, 1'b0);
                if (t) begin
                    checks++;
                    if (overrun !== 1'b1 || overrun_count !== 8'd1 || start !== 4'b0000) begin
                        errors++;
                        $display("FAIL overrun_pulse: got ovr=%b cnt=%0d start=%b expected 1 1 0000",
                                 overrun, overrun_count, start);
                    end
                end
            end
            step(1'b0, 1'b1, 4'(1 << p), 1'b0);
        end
        checks++;
        if (frame_count !== 16'd1 || busy !== 1'b0 || overrun_count !== 8'd1) begin
            errors++;
            $display("FAIL overrun_frame_end: got fc=%0d busy=%b cnt=%0d expected 1 0 1",
                     frame_count, busy, overrun_count);
        end
        step(1'b1, 1'b1, '0, 1'b0);
        checks++;
        if (start !== 4'b0001 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_next_frame: got start=%b ovr=%b expected 0001 0", start, overrun);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b1, '0, 1'b0);
            checks++;
            if (act !== exp_bundle()) begin
                errors++;
                $display("FAIL sat_cycle %0d: got %h expected %h", i, act, exp_bundle());
            end
        end
        checks++;
        if (overrun_count !== 8'd255 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL sat_final: got cnt=%0d terr=%b expected 255 1", overrun_count, timeout_err);
        end
    endtask

    task automatic test_ignored_done();
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        checks++;
        if (start !== 4'b0000 || phase !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_done_in_start: got start=%b phase=%0d busy=%b expected 0000 0 1", start, phase, busy);
        end
        step(1'b0, 1'b1, 4'b0010, 1'b0);
        checks++;
        if (start !== 4'b0000 || phase !== 3'd0) begin
            errors++;
            $display("FAIL ign_other_done: got start=%b phase=%0d expected 0000 0", start, phase);
        end
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        checks++;
        if (start !== 4'b0010 || phase !== 3'd1) begin
            errors++;
            $display("FAIL ign_real_done: got start=%b phase=%0d expected 0010 1", start, phase);
        end
        for (int p = 1; p < NP; p++) begin
            step(1'b0, 1'b1, '0, 1'b0);
            step(1'b0, 1'b1, 4'(1 << p), 1'b0);
        end
        checks++;
        if (act !== exp_bundle() || frame_count !== 16'd1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL ign_frame_end: got %h expected %h", act, exp_bundle());
        end
    endtask

    task automatic test_reset_mid_frame();
        step(1'b0, 1'b0, '0, 1'b1);
        run_frame(1);
        step(1'b1, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, 4'b0010, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (phase !== 3'd2 || busy !== 1'b1 || start !== 4'b0000 || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL rmid_setup: got phase=%0d busy=%b start=%b fc=%0d expected 2 1 0000 1",
                     phase, busy, start, frame_count);
        end
        step(1'b1, 1'b1, 4'b0100, 1'b1);
        checks++;
        if (busy !== 1'b0 || start !== 4'b0000 || phase !== 3'd0 || frame_count !== 16'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset: got busy=%b start=%b phase=%0d fc=%0d ovr=%b expected 0 0000 0 0 0",
                     busy, start, phase, frame_count, overrun);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'b1111, 1'b0);
            checks++;
            if (start !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rmid_quiet %0d: got start=%b busy=%b expected 0000 0", i, start, busy);
            end
        end
        step(1'b1, 1'b1, '0, 1'b0);
        checks++;
        if (start !== 4'b0001) begin
            errors++;
            $display("FAIL rmid_restart: got start=%b expected 0001", start);
        end
    endtask

    task automatic test_enable();
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (busy !== 1'b0 || start !== 4'b0000 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL en_low_tick: got busy=%b start=%b ovr=%b expected 0 0000 0", busy, start, overrun);
            end
        end
        step(1'b1, 1'b1, '0, 1'b0);
        for (int p = 0; p < NP; p++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            step(1'b0, 1'b0, 4'(1 << p), 1'b0);
            checks++;
            if (act !== exp_bundle()) begin
                errors++;
                $display("FAIL en_drop_cycle: got %h expected %h", act, exp_bundle());
            end
        end
        checks++;
        if (frame_count !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_frame: got fc=%0d busy=%b expected 1 0", frame_count, busy);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, '0, 1'b1);
        force dut.frame_count_q = 16'hFFFE;
        #1;
        release dut.frame_count_q;
        m_fc = 16'hFFFE;
        run_frame(1);
        checks++;
        if (frame_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ffff: got %h expected ffff", frame_count);
        end
        run_frame(2);
        checks++;
        if (frame_count !== 16'h0000 || act !== exp_bundle()) begin
            errors++;
            $display("FAIL wrap_zero: got fc=%h bundle=%h expected fc=0000 bundle=%h", frame_count, act, exp_bundle());
        end
    endtask

    task automatic test_random();
        int dly;
        logic t, en;
        logic [NP-1:0] d;
        step(1'b0, 1'b0, '0, 1'b1);
        dly = 1;
        for (int i = 0; i < 900; i++) begin
            if (m_busy != 0 && m_start_cyc == cyc) dly = $urandom_range(1, 5);
            t  = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 3) != 0);
            d  = 4'($urandom_range(0, 15));
            if (m_busy != 0) d[m_phase] = ((cyc - m_start_cyc) == dly);
            step(t, en, d, ($urandom_range(0, 299) == 0));
            checks++;
            if (act !== exp_bundle()) begin
                errors++;
                $display("FAIL random_cycle %0d: got %h expected %h", i, act, exp_bundle());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_frame();
        test_overrun_single();
        test_ignored_done();
        test_reset_mid_frame();
        test_enable();
        test_wrap();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
